regfile_writeback: RTL



---
 rtl/regfile_writeback_if.sv | 30 +++
 rtl/regfile_writeback.sv | 81 ++++++++
 2 files changed

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: ALU/load result inputs, scoreboard lookup and register file write port
interface regfile_writeback_if #(
  parameter int Address_Width = 5,
  parameter int Data_Width = 32
);
  logic alu_valid;
  logic [Address_Width-1:0] alu_rd;
  logic [Data_Width-1:0] alu_data;
  logic ld_valid;
  logic [Address_Width-1:0] ld_rd;
  logic [Data_Width-1:0] ld_data;
  logic ld_ready;
  logic issue_valid;
  logic [Address_Width-1:0] issue_rd;
  logic [Address_Width-1:0] rs1;
  logic [Address_Width-1:0] rs2;
  logic busy_rs1;
  logic busy_rs2;
  logic en;
  logic [Address_Width-1:0] rd;
  logic [Data_Width-1:0] din;
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd, rs1, rs2,
    input ld_ready, busy_rs1, busy_rs2, en, rd, din
  );
  modport slave (
    input alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd, rs1, rs2,
    output ld_ready, busy_rs1, busy_rs2, en, rd, din
  );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and load results onto one register file write port
// via a 2-entry load skid buffer, and tracks pending loads for issue stalls.
module regfile_writeback #(
  parameter int Address_Width = 5,
  parameter int Data_Width = 32,
  parameter int Buf_Depth = 2
) (
  input logic clk,
  input logic rst,
  regfile_writeback_if.slave wb
);
  logic alu_we, ld_acc, pop, bypass, push, sel, ld_wr;
  logic rptr_q, wptr_q;
  logic [1:0] count_q, count_d;
  logic [Address_Width-1:0] buf_rd_q [Buf_Depth];
  logic [Data_Width-1:0] buf_data_q [Buf_Depth];
  logic [Address_Width-1:0] ld_wr_rd, rd_q, rd_d;
  logic [Data_Width-1:0] din_q, din_d;
  logic en_q, en_d;
  logic [2**Address_Width-1:0] pend_q, pend_d;

  assign wb.ld_ready = count_q != 2'd2;
  assign alu_we = wb.alu_valid && wb.alu_rd != '0;
  assign ld_acc = wb.ld_valid && wb.ld_ready;
  assign pop = count_q != 2'd0 && !alu_we;
  assign bypass = count_q == 2'd0 && !alu_we && ld_acc;
  assign push = ld_acc && !bypass;
  assign ld_wr = pop || bypass;
  assign sel = alu_we || ld_wr;
  assign ld_wr_rd = pop ? buf_rd_q[rptr_q] : wb.ld_rd;
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  // x0 loads still take their port slot but never assert the enable
  always_comb begin
    en_d = alu_we || (ld_wr && ld_wr_rd != '0);
    rd_d = alu_we ? wb.alu_rd : ld_wr ? ld_wr_rd : rd_q;
    din_d = alu_we ? wb.alu_data : pop ? buf_data_q[rptr_q] : bypass ? wb.ld_data : din_q;
  end

  // issue set is applied after writeback clear so it wins on the same register
  always_comb begin
    pend_d = pend_q;
    if (ld_wr) pend_d[ld_wr_rd] = 1'b0;
    if (wb.issue_valid) pend_d[wb.issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
      count_q <= 2'd0;
      en_q <= 1'b0;
      rd_q <= '0;
      din_q <= '0;
      pend_q <= '0;
      for (int i = 0; i < Buf_Depth; i++) begin
        buf_rd_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      rptr_q <= rptr_q ^ pop;
      wptr_q <= wptr_q ^ push;
      count_q <= count_d;
      en_q <= en_d;
      rd_q <= rd_d;
      din_q <= din_d;
      pend_q <= pend_d;
      if (push) begin
        buf_rd_q[wptr_q] <= wb.ld_rd;
        buf_data_q[wptr_q] <= wb.ld_data;
      end
    end
  end

  assign wb.en = en_q;
  assign wb.rd = rd_q;
  assign wb.din = din_q;
  assign wb.busy_rs1 = pend_q[wb.rs1];
  assign wb.busy_rs2 = pend_q[wb.rs2];
endmodule
